seg7_hex_capture: RTL and testbench

SEG7_HEX_CAPTURE -- requirements
Module: seg7_hex_capture

---
 rtl/seg7_hex_capture_if.sv | 28 ++
 rtl/seg7_hex_capture.sv | 136 +++++++++++++
 tb/tb_seg7_hex_capture.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/seg7_hex_capture_if.sv
// Seven-segment capture bus: multiplexed display inputs
// and the reconstructed hex frame outputs.
interface seg7_hex_capture_if;
  logic [6:0]  seg_in;
  logic [3:0]  dig_en;
  logic [15:0] value;
  logic [3:0]  digit_ok;
  logic        frame_valid;
  logic        bad_pattern;

  modport master (
    output seg_in,
    output dig_en,
    input  value,
    input  digit_ok,
    input  frame_valid,
    input  bad_pattern
  );

  modport slave (
    input  seg_in,
    input  dig_en,
    output value,
    output digit_ok,
    output frame_valid,
    output bad_pattern
  );
endinterface

// File: rtl/seg7_hex_capture.sv
// Sniffs a multiplexed 4-digit seven-segment display and
// rebuilds the shown hex value once every digit is seen.
module seg7_hex_capture #(
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter int STABLE_CYCLES = 4
) (
  input logic clk,
  input logic rst,
  seg7_hex_capture_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PUBLISH = 2'd2
  } state_e;

  localparam logic [7:0] CMAX = 8'(STABLE_CYCLES);

  function automatic logic [4:0] dec7(input logic [6:0] s);
    case (s)
      7'b1111110: dec7 = 5'h10;
      7'b0110000: dec7 = 5'h11;
      7'b1101101: dec7 = 5'h12;
      7'b1111001: dec7 = 5'h13;
      7'b0110011: dec7 = 5'h14;
      7'b1011011: dec7 = 5'h15;
      7'b1011111: dec7 = 5'h16;
      7'b1110000: dec7 = 5'h17;
      7'b1111111: dec7 = 5'h18;
      7'b1111011: dec7 = 5'h19;
      7'b1110111: dec7 = 5'h1A;
      7'b0011111: dec7 = 5'h1B;
      7'b1001110: dec7 = 5'h1C;
      7'b0111101: dec7 = 5'h1D;
      7'b1001111: dec7 = 5'h1E;
      7'b1000111: dec7 = 5'h1F;
      default:    dec7 = 5'h00;
    endcase
  endfunction

  logic [10:0]      smp_d, smp_q;
  logic [7:0]       cnt_d, cnt_q;
  logic             acc_d, acc_q;
  state_e           state_d, state_q;
  logic [3:0]       seen_d, seen_q;
  logic [3:0][3:0]  digs_d, digs_q;
  logic [3:0]       ok_d, ok_q;
  logic             bad_d, bad_q;
  logic [15:0]      val_d, val_q;

  logic [6:0] seg_hi;
  logic [3:0] dig_hi;
  logic [4:0] dcd;
  logic [1:0] idx;
  logic       one_hot;
  logic       pub;

  always_comb begin
    seg_hi = ACTIVE_LOW ? ~bus.seg_in : bus.seg_in;
    dig_hi = ACTIVE_LOW ? ~bus.dig_en : bus.dig_en;
    smp_d  = {seg_hi, dig_hi};
  end

  // Counter saturates so a long hold yields a single accept.
  always_comb begin
    cnt_d = 8'd1;
    if (smp_d == smp_q) begin
      cnt_d = (cnt_q == CMAX) ? CMAX : cnt_q + 8'd1;
    end
    acc_d = (cnt_d == CMAX) && (cnt_q != CMAX);
  end

  always_comb begin
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (smp_q[i]) idx = 2'(i);
    end
    one_hot = $onehot(smp_q[3:0]);
    dcd     = dec7(smp_q[10:4]);
    pub     = (state_q == PUBLISH);
  end

  always_comb begin
    state_d = pub ? IDLE : state_q;
    seen_d  = pub ? 4'h0 : seen_q;
    val_d   = pub ? digs_q : val_q;
    digs_d  = digs_q;
    ok_d    = ok_q;
    bad_d   = 1'b0;
    if (acc_q && one_hot) begin
      if (dcd[4]) begin
        digs_d[idx] = dcd[3:0];
        ok_d[idx]   = 1'b1;
        seen_d      = seen_d | smp_q[3:0];
        state_d     = (seen_d == 4'hF) ? PUBLISH : COLLECT;
      end else begin
        ok_d[idx] = 1'b0;
        bad_d     = 1'b1;
        seen_d    = 4'h0;
        state_d   = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      state_q <= IDLE;
      seen_q  <= '0;
      digs_q  <= '0;
      ok_q    <= '0;
      bad_q   <= 1'b0;
      val_q   <= '0;
    end else begin
      smp_q   <= smp_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      state_q <= state_d;
      seen_q  <= seen_d;
      digs_q  <= digs_d;
      ok_q    <= ok_d;
      bad_q   <= bad_d;
      val_q   <= val_d;
    end
  end

  // The frame is shown during PUBLISH, then held in val_q.
  assign bus.value       = pub ? digs_q : val_q;
  assign bus.frame_valid = pub;
  assign bus.digit_ok    = ok_q;
  assign bus.bad_pattern = bad_q;

endmodule

// File: tb/tb_seg7_hex_capture.sv
// Directed bench for seg7_hex_capture with a run-length
// reference model checked on every falling edge.
module tb_seg7_hex_capture;
  localparam int S = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg7_hex_capture_if bus();

  seg7_hex_capture #(.ACTIVE_LOW(1'b1), .STABLE_CYCLES(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errs = 0;
  int checks = 0;
  int fv_cnt = 0;
  int bad_cnt = 0;

  logic [6:0] tbl [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: an accept fires when the held input has been
  // captured exactly S times in a row.
  logic [10:0] m_cur;
  int          m_run;
  bit          m_pend;
  logic [3:0]  m_dig [4];
  logic [3:0]  m_ok, m_seen;
  logic [15:0] m_val;
  bit          m_fv, m_bad;
  logic [10:0] m_nw;
  logic [3:0]  m_dd;
  int          m_i, m_hit;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cur = '0; m_run = 0; m_pend = 0;
      for (int k = 0; k < 4; k++) m_dig[k] = 4'h0;
      m_ok = '0; m_seen = '0; m_val = '0;
      m_fv = 0; m_bad = 0;
    end else begin
      m_fv = 0;
      m_bad = 0;
      if (m_pend) begin
        m_dd = m_cur[3:0];
        if ($countones(m_dd) == 1) begin
          m_i = 0;
          for (int k = 0; k < 4; k++) if (m_dd[k]) m_i = k;
          m_hit = -1;
          for (int k = 0; k < 16; k++)
            if (tbl[k] == m_cur[10:4]) m_hit = k;
          if (m_hit >= 0) begin
            m_dig[m_i] = 4'(m_hit);
            m_ok[m_i] = 1'b1;
            m_seen[m_i] = 1'b1;
            if (m_seen == 4'hF) begin
              m_val = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
              m_fv = 1;
              m_seen = '0;
            end
          end else begin
            m_ok[m_i] = 1'b0;
            m_bad = 1;
            m_seen = '0;
          end
        end
      end
      m_nw = {~bus.seg_in, ~bus.dig_en};
      if (m_nw == m_cur) m_run++;
      else m_run = 1;
      m_cur = m_nw;
      m_pend = (m_run == S);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("value", 32'(bus.value), 32'(m_val));
      chk("digit_ok", 32'(bus.digit_ok), 32'(m_ok));
      chk("frame_valid", 32'(bus.frame_valid), 32'(m_fv));
      chk("bad_pattern", 32'(bus.bad_pattern), 32'(m_bad));
      if (bus.frame_valid) fv_cnt++;
      if (bus.bad_pattern) bad_cnt++;
    end
  end

  task automatic drive(input logic [3:0] d, input logic [6:0] s,
                       input int n);
    @(negedge clk);
    bus.dig_en = ~d;
    bus.seg_in = ~s;
    repeat (n) @(posedge clk);
  endtask

  task automatic idle(input int n);
    drive(4'b0000, 7'b0000000, n);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    bus.dig_en = 4'hF;
    bus.seg_in = 7'h7F;
    #12;
    chk("rst_value", 32'(bus.value), 32'h0);
    chk("rst_ok", 32'(bus.digit_ok), 32'h0);
    chk("rst_fv", 32'(bus.frame_valid), 32'h0);
    chk("rst_bad", 32'(bus.bad_pattern), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    idle(5);

    drive(4'b0001, 7'b1111001, 4);
    drive(4'b0010, 7'b1111110, 4);
    drive(4'b0100, 7'b1110111, 4);
    drive(4'b1000, 7'b1000111, 4);
    idle(4);
    settle();
    chk("frame1_cnt", 32'(fv_cnt), 32'd1);
    chk("frame1_val", 32'(bus.value), 32'hFA03);
    chk("frame1_ok", 32'(bus.digit_ok), 32'hF);

    drive(4'b0001, 7'b0110000, 3);
    idle(6);
    settle();
    chk("short_ok", 32'(bus.digit_ok), 32'hF);
    chk("short_val", 32'(bus.value), 32'hFA03);
    chk("short_fv", 32'(fv_cnt), 32'd1);

    drive(4'b0001, 7'b1011011, 4);
    drive(4'b0010, 7'b1011111, 4);
    drive(4'b0100, 7'b1010101, 4);
    idle(4);
    settle();
    chk("bad_cnt", 32'(bad_cnt), 32'd1);
    chk("bad_ok", 32'(bus.digit_ok), 32'b1011);
    chk("bad_val", 32'(bus.value), 32'hFA03);

    drive(4'b0011, 7'b1111111, 10);
    idle(4);
    settle();
    chk("multi_ok", 32'(bus.digit_ok), 32'b1011);
    chk("multi_fv", 32'(fv_cnt), 32'd1);
    chk("multi_bad", 32'(bad_cnt), 32'd1);

    drive(4'b1000, 7'b1110000, 100);
    idle(4);
    settle();
    chk("long_fv", 32'(fv_cnt), 32'd1);
    drive(4'b0001, 7'b0110000, 4);
    drive(4'b0010, 7'b1101101, 4);
    drive(4'b0100, 7'b1001110, 4);
    idle(4);
    settle();
    chk("long_cnt", 32'(fv_cnt), 32'd2);
    chk("long_val", 32'(bus.value), 32'h7C21);
    chk("long_ok", 32'(bus.digit_ok), 32'hF);

    drive(4'b0001, 7'b0111101, 4);
    drive(4'b0010, 7'b1001111, 4);
    idle(5);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_value", 32'(bus.value), 32'h0);
    chk("arst_ok", 32'(bus.digit_ok), 32'h0);
    chk("arst_fv", 32'(bus.frame_valid), 32'h0);
    chk("arst_bad", 32'(bus.bad_pattern), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(4'b0100, 7'b0011111, 4);
    drive(4'b1000, 7'b1111011, 4);
    idle(6);
    settle();
    chk("post_rst_fv", 32'(fv_cnt), 32'd2);
    drive(4'b0001, 7'b0110011, 4);
    drive(4'b0010, 7'b1111110, 4);
    idle(6);
    settle();
    chk("post_rst_cnt", 32'(fv_cnt), 32'd3);
    chk("post_rst_val", 32'(bus.value), 32'h9B04);
    chk("post_rst_ok", 32'(bus.digit_ok), 32'hF);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
